// File: rtl/detector_jogada_pkg.sv
// Shared definitions for the memory-game button detector: FSM state codes,
// default debounce length and the one-hot test used to reject multi-button presses.
package detector_jogada_pkg;

  localparam int unsigned N_BOTOES               = 4;
  localparam int unsigned ESTADO_W               = 4;
  localparam int unsigned DEBOUNCE_CICLOS_PADRAO = 5;

  typedef enum logic [ESTADO_W-1:0] {
    ESPERA      = 4'd0,
    FILTRANDO   = 4'd1,
    PRESSIONADO = 4'd2,
    SOLTANDO    = 4'd3,
    INVALIDO    = 4'd4
  } estado_t;

  // True when exactly one button bit is set.
  function automatic logic eh_one_hot(input logic [N_BOTOES-1:0] v);
    return (v != '0) && ((v & (v - N_BOTOES'(1))) == '0);
  endfunction

endpackage

// File: rtl/detector_jogada_sincronizador_botoes.sv
// Two-flop synchroniser bringing the asynchronous push-buttons into the clock domain.
module sincronizador_botoes
  import detector_jogada_pkg::*;
#(
  parameter int unsigned W = N_BOTOES
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [W-1:0] botoes,
  output logic [W-1:0] s
);

  logic [W-1:0] meta_q, meta_d;
  logic [W-1:0] s_q, s_d;

  always_comb begin
    meta_d = botoes;
    s_d    = meta_q;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      meta_q <= '0;
      s_q    <= '0;
    end else begin
      meta_q <= meta_d;
      s_q    <= s_d;
    end
  end

  assign s = s_q;

endmodule

// File: rtl/detector_jogada.sv
// Debounces the synchronised buttons, rejects multi-button presses and emits one
// registered jogada_feita pulse (with the one-hot code in jogada) per accepted press.
module detector_jogada
  import detector_jogada_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CICLOS = DEBOUNCE_CICLOS_PADRAO
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [N_BOTOES-1:0] botoes,
  input  logic                habilita,
  input  logic                limpa,
  output logic                jogada_feita,
  output logic [N_BOTOES-1:0] jogada,
  output logic                jogada_invalida,
  output logic                tem_jogada,
  output logic [ESTADO_W-1:0] db_estado
);

  localparam int unsigned      CNT_W   = $clog2(DEBOUNCE_CICLOS + 1);
  localparam logic [CNT_W-1:0] CNT_UM  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_FIM = CNT_W'(DEBOUNCE_CICLOS - 1);

  logic [N_BOTOES-1:0] s;

  estado_t             estado_q, estado_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [N_BOTOES-1:0] cand_q, cand_d;
  logic [N_BOTOES-1:0] jogada_q, jogada_d;
  logic                feita_q, feita_d;
  logic                invalida_q, invalida_d;
  logic                tem_q, tem_d;

  sincronizador_botoes #(
    .W (N_BOTOES)
  ) u_sinc (
    .clock  (clock),
    .reset  (reset),
    .botoes (botoes),
    .s      (s)
  );

  // Next-state logic; the accept load of jogada overrides a concurrent limpa.
  always_comb begin
    estado_d   = estado_q;
    cnt_d      = cnt_q;
    cand_d     = cand_q;
    jogada_d   = limpa ? '0 : jogada_q;
    feita_d    = 1'b0;
    invalida_d = 1'b0;
    tem_d      = |s;

    case (estado_q)
      ESPERA: begin
        if (eh_one_hot(s)) begin
          estado_d = FILTRANDO;
          cand_d   = s;
          cnt_d    = CNT_UM;
        end else if (s != '0) begin
          estado_d   = INVALIDO;
          invalida_d = 1'b1;
        end
      end
      FILTRANDO: begin
        if (s == '0) begin
          estado_d = ESPERA;
        end else if (!eh_one_hot(s)) begin
          estado_d   = INVALIDO;
          invalida_d = 1'b1;
        end else if (s != cand_q) begin
          cand_d = s;
          cnt_d  = CNT_UM;
        end else if (cnt_q == CNT_FIM) begin
          estado_d = PRESSIONADO;
          if (habilita) begin
            feita_d  = 1'b1;
            jogada_d = cand_q;
          end
        end else begin
          cnt_d = cnt_q + CNT_UM;
        end
      end
      PRESSIONADO: begin
        if (s == '0) begin
          estado_d = SOLTANDO;
          cnt_d    = CNT_UM;
        end
      end
      SOLTANDO: begin
        // A bounce during release restarts the quiet-time count.
        if (s != '0) begin
          cnt_d = '0;
        end else if (cnt_q == CNT_FIM) begin
          estado_d = ESPERA;
        end else begin
          cnt_d = cnt_q + CNT_UM;
        end
      end
      INVALIDO: begin
        if (s == '0) begin
          estado_d = SOLTANDO;
          cnt_d    = CNT_UM;
        end
      end
      default: estado_d = ESPERA;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado_q   <= ESPERA;
      cnt_q      <= '0;
      cand_q     <= '0;
      jogada_q   <= '0;
      feita_q    <= 1'b0;
      invalida_q <= 1'b0;
      tem_q      <= 1'b0;
    end else begin
      estado_q   <= estado_d;
      cnt_q      <= cnt_d;
      cand_q     <= cand_d;
      jogada_q   <= jogada_d;
      feita_q    <= feita_d;
      invalida_q <= invalida_d;
      tem_q      <= tem_d;
    end
  end

  assign jogada_feita    = feita_q;
  assign jogada          = jogada_q;
  assign jogada_invalida = invalida_q;
  assign tem_jogada      = tem_q;
  assign db_estado       = estado_q;

endmodule

// File: tb/tb_detector_jogada.sv
// Scoreboard bench for detector_jogada: stimulus schedules expected outputs per cycle,
// a negedge monitor compares them and flags any pulse nobody scheduled.
module tb_detector_jogada;
  import detector_jogada_pkg::*;

  logic       clock = 1'b0;
  logic       reset;
  logic [3:0] botoes;
  logic       habilita;
  logic       limpa;
  logic       jogada_feita;
  logic [3:0] jogada;
  logic       jogada_invalida;
  logic       tem_jogada;
  logic [3:0] db_estado;

  detector_jogada #(
    .DEBOUNCE_CICLOS (5)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .botoes          (botoes),
    .habilita        (habilita),
    .limpa           (limpa),
    .jogada_feita    (jogada_feita),
    .jogada          (jogada),
    .jogada_invalida (jogada_invalida),
    .tem_jogada      (tem_jogada),
    .db_estado       (db_estado)
  );

  always #5 clock = ~clock;

  typedef struct {
    int         cyc;
    logic       feita;
    logic       inval;
    logic [3:0] jog;
    logic [3:0] est;
    logic       tem;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   rd_idx   = 0;
  int   cyc      = 0;
  int   n_checks = 0;
  int   n_pass   = 0;
  bit   done     = 1'b0;

  initial forever begin
    @(posedge clock);
    cyc++;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  // Schedule an expected output set for 'off' cycles from now, kept sorted by cycle.
  task automatic expect_at(input int off, input logic f, input logic iv,
                           input logic [3:0] j, input logic [3:0] es, input logic t);
    exp_t x;
    int   k;
    x = '{cyc + off, f, iv, j, es, t};
    k = sb.size();
    while (k > 0 && sb[k-1].cyc > x.cyc) k--;
    sb.insert(k, x);
  endtask

  initial forever begin
    @(negedge clock);
    if (cyc > 2000) begin
      n_checks++;
      $display("FAIL watchdog: cyc=%0d exceeded budget", cyc);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
    end
    while (rd_idx < sb.size() && sb[rd_idx].cyc < cyc) begin
      n_checks++;
      $display("FAIL stale_expectation: cyc=%0d scheduled for %0d", cyc, sb[rd_idx].cyc);
      rd_idx++;
    end
    if (rd_idx < sb.size() && sb[rd_idx].cyc == cyc) begin
      e = sb[rd_idx];
      rd_idx++;
      n_checks++;
      if (jogada_feita === e.feita && jogada_invalida === e.inval && jogada === e.jog &&
          db_estado === e.est && tem_jogada === e.tem) begin
        n_pass++;
      end else begin
        $display("FAIL outputs@cyc=%0d got/exp: feita=%b/%b invalida=%b/%b jogada=%b/%b estado=%0d/%0d tem=%b/%b",
                 cyc, jogada_feita, e.feita, jogada_invalida, e.inval, jogada, e.jog,
                 db_estado, e.est, tem_jogada, e.tem);
      end
    end else if (jogada_feita !== 1'b0 || jogada_invalida !== 1'b0) begin
      n_checks++;
      $display("FAIL unexpected_pulse@cyc=%0d got feita=%b invalida=%b, exp 0/0",
               cyc, jogada_feita, jogada_invalida);
    end
    if (done && rd_idx >= sb.size()) begin
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
    end
  end

  initial begin
    reset    = 1'b0;
    habilita = 1'b0;
    limpa    = 1'b0;
    botoes   = 4'b0000;
    tick(3);

    // Reset state, then idle after release
    expect_at(0, 0, 0, 4'b0000, 4'd0, 0);
    reset = 1'b1;
    expect_at(1, 0, 0, 4'b0000, 4'd0, 0);
    expect_at(5, 0, 0, 4'b0000, 4'd0, 0);
    expect_at(10, 0, 0, 4'b0000, 4'd0, 0);
    tick(10);

    // Clean press 0001: pulse 7 cycles after drive (edge k+6)
    habilita = 1'b1;
    botoes   = 4'b0001;
    expect_at(2, 0, 0, 4'b0000, 4'd0, 0);
    expect_at(3, 0, 0, 4'b0000, 4'd1, 1);
    expect_at(7, 1, 0, 4'b0001, 4'd2, 1);
    expect_at(8, 0, 0, 4'b0001, 4'd2, 1);
    tick(10);
    botoes = 4'b0000;
    expect_at(3, 0, 0, 4'b0001, 4'd3, 0);
    expect_at(6, 0, 0, 4'b0001, 4'd3, 0);
    expect_at(7, 0, 0, 4'b0001, 4'd0, 0);
    tick(10);

    // Bouncing 0010/0000 then steady 0010
    for (int i = 0; i < 8; i++) begin
      botoes = (i % 2 == 0) ? 4'b0010 : 4'b0000;
      tick(1);
    end
    botoes = 4'b0010;
    expect_at(2, 0, 0, 4'b0001, 4'd0, 0);
    expect_at(7, 1, 0, 4'b0010, 4'd2, 1);
    tick(10);
    botoes = 4'b0000;
    expect_at(7, 0, 0, 4'b0010, 4'd0, 0);
    tick(10);

    // Two buttons: invalid pulse, jogada kept
    botoes = 4'b0011;
    expect_at(3, 0, 1, 4'b0010, 4'd4, 1);
    expect_at(4, 0, 0, 4'b0010, 4'd4, 1);
    tick(10);
    botoes = 4'b0000;
    expect_at(3, 0, 0, 4'b0010, 4'd3, 0);
    expect_at(7, 0, 0, 4'b0010, 4'd0, 0);
    tick(10);

    // habilita low at accept: no pulse, and enabling later while held gives none
    habilita = 1'b0;
    botoes   = 4'b0100;
    expect_at(7, 0, 0, 4'b0010, 4'd2, 1);
    tick(8);
    habilita = 1'b1;
    expect_at(2, 0, 0, 4'b0010, 4'd2, 1);
    tick(2);
    botoes = 4'b0000;
    expect_at(7, 0, 0, 4'b0010, 4'd0, 0);
    tick(10);
    botoes = 4'b0100;
    expect_at(7, 1, 0, 4'b0100, 4'd2, 1);
    tick(10);
    botoes = 4'b0000;
    expect_at(7, 0, 0, 4'b0100, 4'd0, 0);
    tick(10);

    // Reset while holding 1000, re-debounce after release, then limpa
    botoes = 4'b1000;
    expect_at(7, 1, 0, 4'b1000, 4'd2, 1);
    tick(10);
    reset = 1'b0;
    expect_at(0, 0, 0, 4'b0000, 4'd0, 0);
    tick(1);
    reset = 1'b1;
    expect_at(0, 0, 0, 4'b0000, 4'd0, 0);
    expect_at(3, 0, 0, 4'b0000, 4'd1, 1);
    expect_at(7, 1, 0, 4'b1000, 4'd2, 1);
    tick(8);
    expect_at(0, 0, 0, 4'b1000, 4'd2, 1);
    limpa = 1'b1;
    expect_at(1, 0, 0, 4'b0000, 4'd2, 1);
    tick(1);
    limpa  = 1'b0;
    botoes = 4'b0000;
    expect_at(7, 0, 0, 4'b0000, 4'd0, 0);
    tick(10);

    // limpa held across an accept: accept wins, then cleared next edge
    limpa  = 1'b1;
    botoes = 4'b0001;
    expect_at(7, 1, 0, 4'b0001, 4'd2, 1);
    expect_at(8, 0, 0, 4'b0000, 4'd2, 1);
    tick(10);
    limpa  = 1'b0;
    botoes = 4'b0000;
    expect_at(7, 0, 0, 4'b0000, 4'd0, 0);
    tick(10);

    done = 1'b1;
  end

endmodule

// File: doc/detector_jogada.md
Name: detector_jogada

Overview:
- Button-conditioning stage directly upstream of the memory-game datapath/control unit.
- Synchronises the raw `botoes[3:0]` inputs, debounces them and rejects multi-button presses.
- Emits a single-cycle `jogada_feita` pulse per accepted press, with the one-hot code held in `jogada`.
- Replaces the raw-edge detection that currently feeds the jogada register and comparator.

Parameters:
DEBOUNCE_CICLOS, 5, consecutive identical synchronised samples required to accept a press or a release (legal range >= 2; 5 ms at the 1 kHz board clock)

Ports:
clock  in  1  system clock (1 kHz on board)
reset  in  1  asynchronous, active-low reset
botoes  in  4  raw push-buttons, asynchronous, active-high
habilita  in  1  control unit is awaiting a play; gates pulse and jogada update
limpa  in  1  synchronous clear of `jogada` register
jogada_feita  out  1  one-cycle pulse: valid debounced press accepted
jogada  out  4  registered one-hot code of last accepted press
jogada_invalida  out  1  one-cycle pulse: more than one button detected
tem_jogada  out  1  OR of synchronised buttons (raw activity, for db_tem_jogada)
db_estado  out  4  FSM state code

Behaviour:
- Reset (reset=0, asynchronous):
  - sync flops, counter and candidate cleared; state ESPERA.
  - jogada=0000; jogada_feita=0, jogada_invalida=0, tem_jogada=0.
  - After reset release, a still-held button is re-debounced from scratch and produces a pulse.
- Synchroniser: 2 flops, reset to 0; output s. tem_jogada = |s (registered path only, no raw-input logic).
- FSM states and db_estado codes: ESPERA=0, FILTRANDO=1, PRESSIONADO=2, SOLTANDO=3, INVALIDO=4; 5..15 unused → ESPERA.
- ESPERA:
  - s==0: stay.
  - s one-hot: → FILTRANDO, candidate=s, cnt=1.
  - s nonzero and not one-hot: → INVALIDO, jogada_invalida=1 for one cycle.
- FILTRANDO:
  - s==0: → ESPERA (bounce rejected).
  - s one-hot ≠ candidate: candidate=s, cnt=1.
  - s multi-bit: → INVALIDO with pulse.
  - s==candidate and cnt<DEBOUNCE_CICLOS-1: cnt++.
  - s==candidate and cnt==DEBOUNCE_CICLOS-1: → PRESSIONADO.
    - If habilita=1 at that edge: jogada_feita=1 and jogada=candidate.
    - Else: no pulse, jogada unchanged.
- PRESSIONADO: any nonzero s is ignored, including a change of button. s==0 → SOLTANDO, cnt=1.
- SOLTANDO:
  - s==0: cnt++; at cnt==DEBOUNCE_CICLOS-1 → ESPERA.
  - s nonzero: stay, cnt=0 (release bounce restarts the count, no new pulse).
- INVALIDO: wait for s==0 → SOLTANDO, cnt=1. jogada unchanged.
- Latency:
  - Value first sampled by sync flop 1 at edge k → jogada_feita high for exactly the cycle after edge k+DEBOUNCE_CICLOS+1.
  - With default DEBOUNCE_CICLOS=5: pulse after edge k+6.
- Pulses last exactly one cycle; at most one jogada_feita per press/release pair.
- limpa=1: jogada←0000 next edge. If limpa and an accept occur on the same edge, the accept wins (candidate loaded).
- Counter width = clog2(DEBOUNCE_CICLOS+1); it never wraps because every state saturates or exits at DEBOUNCE_CICLOS-1.
- No combinational path from botoes to any output.

Decomposition:
- Shared package: state encodings (ESPERA..INVALIDO), default DEBOUNCE_CICLOS, a one-hot check function. The package is reused by the top-level hex display decode of db_estado.
- One sub-module: sincronizador_botoes (2-flop, 4-bit, async active-low reset).
- FSM, counter, candidate and output registers stay in detector_jogada.

Test Plan:
1. Reset pulse low, botoes=0000 → all outputs 0, db_estado=0; hold 10 cycles, nothing changes.
2. habilita=1, botoes=0001 for 10 cycles then 0000 → exactly one jogada_feita pulse, after edge k+6; jogada=0001 held after release; db_estado sequence 0,1,2,3,0.
3. habilita=1, botoes toggles 0010/0000 every cycle for 8 cycles, then steady 0010 → no pulse during toggling; one pulse 6 edges after steady start; jogada=0010.
4. botoes=0011 for 10 cycles → jogada_invalida pulse once, no jogada_feita, jogada unchanged, db_estado=4 then 3, then 0 after release.
5. habilita=0, botoes=0100 for 10 cycles → no pulse, jogada unchanged. Then habilita=1 while still held → still no pulse until release and a new press.
6. Press 1000 accepted, then reset low mid-press for 1 cycle while held → outputs cleared immediately; after release of reset, new pulse with jogada=1000 after full debounce. Then limpa=1 for one cycle → jogada=0000.
